// File: rtl/conv_pkg.sv
// Shared types, kernel table and helpers for the 3x3 convolution stage.
// Optional clip flags are enabled with the KERNEL_CONVOLVE_CLIP_FLAG_EN macro.
package conv_pkg;

    localparam int PIPE_LATENCY = 4;
    localparam int PIX_W        = 6;
    localparam int COEF_W       = 8;
    localparam int PROD_W       = 15;   // 7-bit non-negative pixel x 8-bit signed coefficient

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb666_t;

    typedef logic signed [COEF_W-1:0] coef_t;

    // Coefficients are row-major, index 0 = top-left, index 8 = bottom-right.
    typedef struct packed {
        coef_t [0:8] coef;
        logic  [2:0] shift;
    } kernel_t;

    localparam kernel_t KERNELS [0:7] = '{
        '{coef: '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0}, shift: 3'd0},
        '{coef: '{8'sd1, 8'sd2, 8'sd1, 8'sd2, 8'sd4, 8'sd2, 8'sd1, 8'sd2, 8'sd1}, shift: 3'd4},
        '{coef: '{8'sd0, -8'sd1, 8'sd0, -8'sd1, 8'sd5, -8'sd1, 8'sd0, -8'sd1, 8'sd0}, shift: 3'd0},
        '{coef: '{-8'sd1, -8'sd1, -8'sd1, -8'sd1, 8'sd8, -8'sd1, -8'sd1, -8'sd1, -8'sd1}, shift: 3'd0},
        '{coef: '{-8'sd1, 8'sd0, 8'sd1, -8'sd2, 8'sd0, 8'sd2, -8'sd1, 8'sd0, 8'sd1}, shift: 3'd0},
        '{coef: '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0}, shift: 3'd0},
        '{coef: '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0}, shift: 3'd0},
        '{coef: '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0}, shift: 3'd0}
    };

    // Zero-extended pixel times sign-extended coefficient, at full product width.
    function automatic logic signed [PROD_W-1:0] pix_mul(input logic [PIX_W-1:0] p,
                                                         input logic [COEF_W-1:0] c);
        logic signed [PROD_W-1:0] p_ext;
        logic signed [PROD_W-1:0] c_ext;
        p_ext   = $signed({{(PROD_W-PIX_W){1'b0}}, p});
        c_ext   = $signed({{(PROD_W-COEF_W){c[COEF_W-1]}}, c});
        pix_mul = p_ext * c_ext;
    endfunction

endpackage

// File: rtl/conv_channel_mac.sv
// One colour channel of the 3x3 filter: registered products, then
// sum / arithmetic shift / clamp registered onto the output.
// KERNEL_CONVOLVE_CLIP_FLAG_EN adds a per-channel clip flag.
module conv_channel_mac
    import conv_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:8][PIX_W-1:0] pix_in,
    input  kernel_t               kern_in,
    input  logic                  valid_in,   // aligned with the product registers
    output logic [PIX_W-1:0]      pix_out
`ifdef KERNEL_CONVOLVE_CLIP_FLAG_EN
    ,
    output logic                  clip_out
`endif
);

    logic signed [PROD_W-1:0] prod_d [9];
    logic signed [PROD_W-1:0] prod_q [9];
    logic [2:0]               shift_d, shift_q;
    logic signed [ACC_W-1:0]  acc, acc_shr;
    logic                     neg, over;
    logic [PIX_W-1:0]         pix_d, pix_q;
    logic                     clip_d, clip_q;

    // Products of the window with the kernel, plus the shift that goes with them
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            prod_d[i] = pix_mul(pix_in[i], kern_in.coef[i]);
        end
        shift_d = kern_in.shift;
    end

    // Sum, floor-shift and clamp to 0..63; invalid pixels are forced to zero
    always_comb begin
        acc = '0;
        for (int i = 0; i < 9; i++) begin
            acc = acc + {{(ACC_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
        end
        acc_shr = acc >>> shift_q;
        neg     = acc_shr[ACC_W-1];
        over    = !neg && (acc_shr[ACC_W-2:PIX_W] != '0);
        if (!valid_in) begin
            pix_d = '0;
        end else if (neg) begin
            pix_d = '0;
        end else if (over) begin
            pix_d = '1;
        end else begin
            pix_d = acc_shr[PIX_W-1:0];
        end
        clip_d = valid_in && (neg || over);
    end

    // Pipeline registers for products and the final channel value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                prod_q[i] <= '0;
            end
            shift_q <= '0;
            pix_q   <= '0;
            clip_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                prod_q[i] <= prod_d[i];
            end
            shift_q <= shift_d;
            pix_q   <= pix_d;
            clip_q  <= clip_d;
        end
    end

    assign pix_out = pix_q;

`ifdef KERNEL_CONVOLVE_CLIP_FLAG_EN
    assign clip_out = clip_q;
`else
    logic unused_clip;
    assign unused_clip = clip_q;
`endif

endmodule

// File: rtl/kernel_convolve.sv
// 3x3 spatial convolution on RGB666 columns from the line buffer.
// Four register stages: column wait, window+kernel, products, sum/clamp.
// KERNEL_CONVOLVE_CLIP_FLAG_EN adds clip_out[2:0] = {R,G,B} clip flags.
module kernel_convolve
    import conv_pkg::*;
#(
    parameter int HRES  = 1280,
    parameter int VRES  = 720,
    parameter int ACC_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0][17:0]  rows_in,
    input  logic [10:0]       h_count_in,
    input  logic [9:0]        v_count_in,
    input  logic [2:0]        kernel_sel,
    output logic [17:0]       pixel_out,
    output logic [10:0]       h_count_out,
    output logic [9:0]        v_count_out,
    output logic              valid_out
`ifdef KERNEL_CONVOLVE_CLIP_FLAG_EN
    ,
    output logic [2:0]        clip_out
`endif
);

    localparam logic [10:0] HRES_C = 11'(HRES);
    localparam logic [9:0]  VRES_C = 10'(VRES);

    logic [2:0][17:0] col_in;
    logic [2:0][17:0] col_d [2];        // [0] = older column, [1] = newer column
    logic [2:0][17:0] col_q [2];
    logic [0:8][17:0] win_d, win_q;     // row-major, left column first
    logic [2:0]       kern_act_d, kern_act_q;
    logic [2:0]       kern_b_d, kern_b_q;
    logic [10:0]      h_d [PIPE_LATENCY];
    logic [10:0]      h_q [PIPE_LATENCY];
    logic [9:0]       v_d [PIPE_LATENCY];
    logic [9:0]       v_q [PIPE_LATENCY];
    logic             valid_d [PIPE_LATENCY];
    logic             valid_q [PIPE_LATENCY];
    kernel_t          kern_b;
    rgb666_t          pix_rgb;
    logic [2:0]       clip_all;

    // Blanking columns enter the window as zeros; the window is assembled from
    // the two held columns plus the incoming one, centred on the previous column
    always_comb begin
        col_in = (h_count_in < HRES_C) ? rows_in : '0;
        col_d[0] = col_q[1];
        col_d[1] = col_in;
        for (int r = 0; r < 3; r++) begin
            win_d[r*3+0] = col_q[0][r];
            win_d[r*3+1] = col_q[1][r];
            win_d[r*3+2] = col_in[r];
        end
        kern_act_d = (h_count_in == '0 && v_count_in == '0) ? kernel_sel : kern_act_q;
        kern_b_d   = kern_act_q;
    end

    // Centre-pixel coordinates and active flag follow the data through every stage
    always_comb begin
        h_d[0]     = h_count_in;
        v_d[0]     = v_count_in;
        valid_d[0] = (h_count_in < HRES_C) && (v_count_in < VRES_C);
        for (int s = 1; s < PIPE_LATENCY; s++) begin
            h_d[s]     = h_q[s-1];
            v_d[s]     = v_q[s-1];
            valid_d[s] = valid_q[s-1];
        end
    end

    // Window, kernel latch and coordinate pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q[0]   <= '0;
            col_q[1]   <= '0;
            win_q      <= '0;
            kern_act_q <= '0;
            kern_b_q   <= '0;
            for (int s = 0; s < PIPE_LATENCY; s++) begin
                h_q[s]     <= '0;
                v_q[s]     <= '0;
                valid_q[s] <= 1'b0;
            end
        end else begin
            col_q[0]   <= col_d[0];
            col_q[1]   <= col_d[1];
            win_q      <= win_d;
            kern_act_q <= kern_act_d;
            kern_b_q   <= kern_b_d;
            for (int s = 0; s < PIPE_LATENCY; s++) begin
                h_q[s]     <= h_d[s];
                v_q[s]     <= v_d[s];
                valid_q[s] <= valid_d[s];
            end
        end
    end

    assign kern_b = KERNELS[kern_b_q];

    // One MAC per colour channel: gi=0 red, gi=1 green, gi=2 blue
    for (genvar gi = 0; gi < 3; gi++) begin : gen_ch
        logic [0:8][PIX_W-1:0] ch_win;
        logic                  ch_clip;

        // Pick this channel's 6-bit field out of every window pixel
        always_comb begin
            for (int i = 0; i < 9; i++) begin
                ch_win[i] = win_q[i][17-6*gi -: 6];
            end
        end

        conv_channel_mac #(
            .ACC_W (ACC_W)
        ) u_mac (
            .clk      (clk),
            .rst      (rst),
            .pix_in   (ch_win),
            .kern_in  (kern_b),
            .valid_in (valid_q[2]),
            .pix_out  (pix_rgb[17-6*gi -: 6])
`ifdef KERNEL_CONVOLVE_CLIP_FLAG_EN
            ,
            .clip_out (ch_clip)
`endif
        );

`ifndef KERNEL_CONVOLVE_CLIP_FLAG_EN
        assign ch_clip = 1'b0;
`endif
        assign clip_all[2-gi] = ch_clip;
    end

    assign pixel_out   = pix_rgb;
    assign h_count_out = h_q[PIPE_LATENCY-1];
    assign v_count_out = v_q[PIPE_LATENCY-1];
    assign valid_out   = valid_q[PIPE_LATENCY-1];

`ifdef KERNEL_CONVOLVE_CLIP_FLAG_EN
    assign clip_out = clip_all;
`else
    logic unused_clip_all;
    assign unused_clip_all = ^clip_all;
`endif

endmodule

// File: tb/tb_kernel_convolve.sv
// Bench for kernel_convolve: small raster, per-frame image patterns and
// kernels, random kernel_sel noise away from (0,0), random blanking data,
// a mid-line reset, and a frame-level behavioural model of the filter.
module tb_kernel_convolve;

    localparam int HR   = 16;
    localparam int VR   = 6;
    localparam int HT   = 20;
    localparam int VT   = 8;
    localparam int NMAX = 4096;
    localparam int NFRM = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0][17:0] rows_in;
    logic [10:0]      h_count_in;
    logic [9:0]       v_count_in;
    logic [2:0]       kernel_sel;
    logic [17:0]      pixel_out;
    logic [10:0]      h_count_out;
    logic [9:0]       v_count_out;
    logic             valid_out;
`ifdef KERNEL_CONVOLVE_CLIP_FLAG_EN
    logic [2:0]       clip_out;
`endif

    always #5 clk = ~clk;

    kernel_convolve #(
        .HRES  (HR),
        .VRES  (VR),
        .ACC_W (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rows_in     (rows_in),
        .h_count_in  (h_count_in),
        .v_count_in  (v_count_in),
        .kernel_sel  (kernel_sel),
        .pixel_out   (pixel_out),
        .h_count_out (h_count_out),
        .v_count_out (v_count_out),
        .valid_out   (valid_out)
`ifdef KERNEL_CONVOLVE_CLIP_FLAG_EN
        ,
        .clip_out    (clip_out)
`endif
    );

    // Reference kernel table
    int kc [8][9];
    int ks [8];

    // Per-cycle record of what was presented to the DUT
    logic [17:0] hc [NMAX][3];
    int          hh [NMAX];
    int          hv [NMAX];
    int          hk [NMAX];
    bit          hr [NMAX];
    int          cyc;
    int          act_k;

    int          img [VR][HR];
    int          n_cmp;
    int          n_err;

    task automatic expect_eq(input string tag, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s obs=%0d: got 0x%0h want 0x%0h", tag, cyc, got, want);
        end
    endtask

    function automatic int floor_shift(input int s, input int sh);
        int d, q;
        d = 1 << sh;
        q = s / d;
        if ((s % d) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic int pix_at(input int x, input int y);
        if (x < 0 || x >= HR || y < 0 || y >= VR) return 0;
        return img[y][x];
    endfunction

    // Channel value of row r of the column recorded at cycle j, as seen by the filter
    function automatic int col_pix(input int j, input int r, input int ch);
        if (hr[j] || hh[j] >= HR) return 0;
        return int'((hc[j][r] >> (12 - 6*ch)) & 18'h3f);
    endfunction

    // Compare the outputs seen after cycle k's edge against the model
    task automatic check_obs(input int k);
        int  c, sum, s, exp_px, exp_h, exp_v, exp_val, exp_clip, kk;
        bit  zero;
        zero = 0;
        for (int j = k - 3; j <= k; j++) if (hr[j]) zero = 1;
        exp_px = 0; exp_h = 0; exp_v = 0; exp_val = 0; exp_clip = 0;
        if (!zero) begin
            c       = k - 3;
            exp_h   = hh[c];
            exp_v   = hv[c];
            exp_val = (hh[c] < HR && hv[c] < VR) ? 1 : 0;
            kk      = hk[c];
            if (exp_val == 1) begin
                for (int ch = 0; ch < 3; ch++) begin
                    sum = 0;
                    for (int r = 0; r < 3; r++)
                        for (int dc = 0; dc < 3; dc++)
                            sum += kc[kk][r*3+dc] * col_pix(c - 1 + dc, r, ch);
                    s = floor_shift(sum, ks[kk]);
                    if (s < 0 || s > 63) exp_clip |= (4 >> ch);
                    if (s < 0) s = 0;
                    if (s > 63) s = 63;
                    exp_px |= s << (12 - 6*ch);
                end
            end
        end
        expect_eq("pixel_out", int'(pixel_out), exp_px);
        expect_eq("h_count_out", int'(h_count_out), exp_h);
        expect_eq("v_count_out", int'(v_count_out), exp_v);
        expect_eq("valid_out", int'(valid_out), exp_val);
`ifdef KERNEL_CONVOLVE_CLIP_FLAG_EN
        expect_eq("clip_out", int'(clip_out), exp_clip);
`endif
    endtask

    // Present one column, record it, clock it and check the outputs
    task automatic step(input bit r, input int h, input int v, input int sel);
        rst        = r;
        h_count_in = 11'(h);
        v_count_in = 10'(v);
        kernel_sel = 3'(sel);
        for (int row = 0; row < 3; row++) begin
            if (h < HR) rows_in[row] = 18'(pix_at(h, v - 1 + row));
            else        rows_in[row] = 18'($urandom);
        end
        if (r)                      act_k = 0;
        else if (h == 0 && v == 0)  act_k = sel;
        hr[cyc] = r;
        hh[cyc] = h;
        hv[cyc] = v;
        hk[cyc] = act_k;
        for (int row = 0; row < 3; row++) hc[cyc][row] = rows_in[row];
        @(posedge clk);
        #1;
        check_obs(cyc);
        cyc++;
    endtask

    task automatic fill_image(input int mode);
        for (int y = 0; y < VR; y++) begin
            for (int x = 0; x < HR; x++) begin
                int g;
                case (mode)
                    0: g = (x * 4) % 64;
                    1: g = 63;
                    2: g = (x == 8 && y == 3) ? 63 : 0;
                    3: g = (x >= HR/2) ? 63 : 0;
                    default: g = -1;
                endcase
                if (g < 0) img[y][x] = int'($urandom_range(0, 18'h3ffff));
                else       img[y][x] = (g << 12) | (g << 6) | g;
            end
        end
    endtask

    initial begin
        int sel_tab [5] = '{0, 1, 2, 4, 3};
        int sel, mode;
        kc[0] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};            ks[0] = 0;
        kc[1] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};            ks[1] = 4;
        kc[2] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};        ks[2] = 0;
        kc[3] = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};    ks[3] = 0;
        kc[4] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};         ks[4] = 0;
        for (int i = 5; i < 8; i++) begin
            kc[i] = kc[0];
            ks[i] = 0;
        end
        n_cmp = 0;
        n_err = 0;
        act_k = 0;
        for (int i = 0; i < 4; i++) begin
            hr[i] = 1; hh[i] = 0; hv[i] = 0; hk[i] = 0;
            for (int row = 0; row < 3; row++) hc[i][row] = '0;
        end
        cyc = 4;
        fill_image(1);

        for (int i = 0; i < 3; i++) step(1, HT - 1, VT - 1, 0);

        for (int f = 0; f < NFRM; f++) begin
            if (f < 5) begin
                sel  = sel_tab[f];
                mode = (f < 4) ? f : 4;
            end else begin
                sel  = int'($urandom_range(0, 7));
                mode = int'($urandom_range(0, 4));
            end
            fill_image(mode);
            $display("frame %0d: kernel_sel=%0d pattern=%0d start_obs=%0d", f, sel, mode, cyc);
            for (int v = 0; v < VT; v++) begin
                for (int h = 0; h < HT; h++) begin
                    bit r;
                    r = (f == 6 && v == 2 && (h == 7 || h == 8));
                    step(r, h, v, (h == 0 && v == 0) ? sel : int'($urandom_range(0, 7)));
                end
            end
        end

        for (int i = 0; i < 6; i++) step(0, HR + 1 + (i % 3), VT - 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/kernel_convolve.md
Name: kernel_convolve

Overview:
- 3x3 spatial convolution stage. It consumes the three vertically aligned pixel rows produced each cycle by the line buffer and emits one filtered RGB666 pixel per cycle.
- Sits directly downstream of the line buffer, ahead of video output muxing.
- The filter is run-time selectable from a fixed kernel table. Selection changes only at frame start, so there is no tearing.

Parameters:
- HRES, 1280, active pixels per line
- VRES, 720, active lines per frame
- ACC_W, 20, signed accumulator width per colour channel

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rows_in  in  [2:0][17:0]  column of pixels: [0]=line above centre, [1]=centre line, [2]=line below; RGB666 as R[17:12] G[11:6] B[5:0]
- h_count_in  in  11  h position of rows_in (centre line coordinates)
- v_count_in  in  10  v position of centre line
- kernel_sel  in  3  requested kernel index
- pixel_out  out  18  filtered RGB666 pixel
- h_count_out  out  11  h of the centre pixel that produced pixel_out
- v_count_out  out  10  v of the centre pixel that produced pixel_out
- valid_out  out  1  centre pixel was active (h<HRES, v<VRES)

Behaviour:
- Upstream delivers one column every clk, including blanking. There is no stall or handshake.
- Column active = h_count_in<HRES. Inactive columns shift zero into the window. Vertical edges arrive already zeroed from upstream.
- Window:
  - 3x3 register array; shifts one column every cycle (newest column = right).
  - Centre column = the column presented one cycle earlier.
  - At h=0 the left column is zero (blanking preceded it). At h=HRES-1 the right column is zero.
- Kernel table (coefficients signed 8-bit, row-major top-left first, plus a right-shift amount):
  - 0 identity: centre 1, shift 0
  - 1 gaussian: 1 2 1 / 2 4 2 / 1 2 1, shift 4
  - 2 sharpen: 0 -1 0 / -1 5 -1 / 0 -1 0, shift 0
  - 3 ridge: -1 -1 -1 / -1 8 -1 / -1 -1 -1, shift 0
  - 4 sobel_x: -1 0 1 / -2 0 2 / -1 0 1, shift 0
  - 5-7: treated as identity
- Kernel latch:
  - Active kernel register loads kernel_sel only on the cycle h_count_in==0 && v_count_in==0.
  - At any other time the active kernel holds its value.
  - Reset value: 0 (identity).
- Arithmetic, per channel independently:
  - Each product = zero-extended 6-bit pixel × signed coefficient.
  - The nine products are summed in ACC_W signed.
  - The sum is arithmetically shifted right by the kernel's shift amount (floor).
  - The result is clamped to 0..63.
- Pipeline and latency:
  - Stage A: column wait / window shift.
  - Stage B: window + kernel registered.
  - Stage C: products registered.
  - Stage D: sum/shift/clamp registered onto the outputs.
  - Output for the centre column presented at cycle t appears at cycle t+4.
  - h_count_out, v_count_out and valid_out travel through matching delay registers. They are the centre pixel's counts exactly, not adjusted.
- valid_out=0 ⇒ pixel_out=0. Active-kernel changes apply to the pipeline at stage B.
- Reset:
  - All pipeline registers, window and outputs go to 0.
  - Active kernel goes to 0.
  - Reset mid-frame produces zero outputs until refilled. The first valid output appears 4 cycles after the first active column following release, with the window rebuilt from zeros.

Optional Feature:
- Macro KERNEL_CONVOLVE_CLIP_FLAG_EN.
- Defined:
  - Adds output clip_out [2:0], registered aligned with pixel_out, one bit per channel {R,G,B}.
  - A bit is high when the shifted sum was <0 or >63. It is forced 0 when valid_out=0. Reset value 0.
- Undefined: port absent; no logic. Behaviour otherwise identical.

Decomposition:
- Package conv_pkg:
  - rgb666_t packed struct
  - kernel_t (9 signed 8-bit coefficients + 3-bit shift)
  - KERNELS constant array [0:7]
  - PIPE_LATENCY=4
- Sub-module conv_channel_mac: one instance per colour channel. Registered products, then sum/shift/clamp (and clip bit when enabled).

Test Plan:
- Reset, kernel_sel=0; drive a ramp with R=G=B=h%64 on all rows → pixel_out at t+4 equals the centre input; counts match the centre; valid_out=0 during h>=HRES.
- kernel_sel=1 latched at (0,0); uniform 63 on all rows → interior 63; h=0 and h=HRES-1 give 47 (756>>4).
- kernel_sel=2; single pixel 63 on zero background → centre 63 (clamped, clip R/G/B=1 if enabled); left/right/up/down neighbours 0 (clamped from -63).
- kernel_sel=4; left half 0, right half 63 (edge at h=640) → h=639 and h=640 both output 63; other columns 0.
- Change kernel_sel 0→3 at h=100,v=50 → no output change until the (0,0) cycle; change visible on the next frame's first valid output.
- Assert rst mid-line at h=300 for 2 cycles → all outputs 0 next cycle, active kernel = identity; outputs resume correctly 4 cycles after the next active column.
